// File: rtl/jk_drive_sequencer_if.sv
// Command handshake bundle between a command source and jk_drive_sequencer.
// The master offers {cmd_op, cmd_cnt} with cmd_valid; the slave answers with cmd_ready.
interface jk_drive_sequencer_if #(
  parameter int REPEAT_W = 4
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [REPEAT_W-1:0] cmd_cnt;

  modport master (output cmd_valid, output cmd_op, output cmd_cnt, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_cnt, output cmd_ready);
endinterface

// File: rtl/jk_drive_sequencer.sv
// FIFO-buffered J/K drive sequencer for a master-slave JK stage.
// Define JKSEQ_CHECK_EN to build the flip-flop state checker (exp_q/err); otherwise both are tied low.
module jk_drive_sequencer #(
  parameter int DEPTH    = 4,
  parameter int REPEAT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  jk_drive_sequencer_if.slave        cmd,
  output logic                       j,
  output logic                       k,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level,
  input  logic                       q_fb,
  output logic                       exp_q,
  output logic                       err,
  input  logic                       err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [1:0]          op;
    logic [REPEAT_W-1:0] cnt;
  } entry_t;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  entry_t              r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]       r_level;
  state_t              r_state, w_state_nxt;
  logic                r_j, r_k;
  logic [REPEAT_W-1:0] r_rem, w_rem_nxt;
  logic [1:0]          w_jk_nxt;
  logic                w_pop, w_push, w_full, w_empty;
  entry_t              w_head;
  logic [REPEAT_W-1:0] w_head_cnt;

  assign w_full        = (r_level == LW'(DEPTH));
  assign w_empty       = (r_level == '0);
  // A pop on the same edge does not make room for a push: acceptance depends on full alone.
  assign w_push        = cmd.cmd_valid && !w_full;
  assign cmd.cmd_ready = !w_full;
  assign w_head        = r_mem[r_rd_ptr];
  assign w_head_cnt    = (w_head.cnt == '0) ? REPEAT_W'(1) : w_head.cnt;

  // NOTE: the storage array is deliberately not reset; clearing pointers and level discards its contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{op: cmd.cmd_op, cnt: cmd.cmd_cnt};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // NOTE: every always_comb output is given a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_jk_nxt    = {r_j, r_k};
    w_rem_nxt   = r_rem;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_jk_nxt    = w_head.op;
          w_rem_nxt   = w_head_cnt;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_rem_nxt = r_rem - REPEAT_W'(1);
        if (r_rem <= REPEAT_W'(1)) begin
          if (!w_empty) begin
            // Chain straight into the next command so j/k stay contiguous.
            w_pop     = 1'b1;
            w_jk_nxt  = w_head.op;
            w_rem_nxt = w_head_cnt;
          end else begin
            w_jk_nxt    = 2'b00;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_rem   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      {r_j, r_k}   <= w_jk_nxt;
      r_rem        <= w_rem_nxt;
    end
  end

  assign j     = r_j;
  assign k     = r_k;
  assign busy  = (r_state == S_ISSUE);
  assign level = r_level;

`ifdef JKSEQ_CHECK_EN
  logic r_exp_q, r_exp_known, r_err;
  logic w_mismatch;

  // Compare uses pre-edge model state, which the stage's slave reflects one cycle after capture.
  assign w_mismatch = r_exp_known && (q_fb != r_exp_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp_q     <= 1'b0;
      r_exp_known <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case ({r_j, r_k})
        2'b01: begin
          r_exp_q     <= 1'b0;
          r_exp_known <= 1'b1;
        end
        2'b10: begin
          r_exp_q     <= 1'b1;
          r_exp_known <= 1'b1;
        end
        2'b11:   r_exp_q <= ~r_exp_q;
        default: r_exp_q <= r_exp_q;
      endcase
      if (w_mismatch)   r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  assign exp_q = r_exp_q;
  assign err   = r_err;
`else
  logic w_unused_chk;
  assign w_unused_chk = ^{q_fb, err_clr};
  assign exp_q        = 1'b0;
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Directed bench for jk_drive_sequencer with a behavioural master-slave JK stage on the feedback path.
// Expected j/k per busy cycle are queued when a command is accepted and popped as the DUT drives them.
module tb_jk_drive_sequencer;
  localparam int DEPTH = 4;
  localparam int RW    = 4;
`ifdef JKSEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       j, k, busy;
  logic [2:0] level;
  logic       q_fb, exp_q, err, err_clr;

  always #5 clk = ~clk;

  jk_drive_sequencer_if #(.REPEAT_W(RW)) cmd_if ();

  jk_drive_sequencer #(.DEPTH(DEPTH), .REPEAT_W(RW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd     (cmd_if),
    .j       (j),
    .k       (k),
    .busy    (busy),
    .level   (level),
    .q_fb    (q_fb),
    .exp_q   (exp_q),
    .err     (err),
    .err_clr (err_clr)
  );

  // JK stage: master captures at rising edge, slave follows on falling edge; never reset.
  logic jk_m, jk_s;
  always @(posedge clk) begin
    case ({j, k})
      2'b01:   jk_m <= 1'b0;
      2'b10:   jk_m <= 1'b1;
      2'b11:   jk_m <= ~jk_s;
      default: jk_m <= jk_m;
    endcase
  end
  always @(negedge clk) jk_s <= jk_m;

  int   fb_mode;  // 0: track stage, 1: inverted, 2: fb_val
  logic fb_val;
  assign q_fb = (fb_mode == 0) ? jk_s : (fb_mode == 1) ? ~jk_s : fb_val;

  logic [1:0] sb_q [$];
  int   total = 0;
  int   bad   = 0;
  int   busy_cycles, busy_runs;
  logic prev_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // One clock; while busy, the driven j/k must match the next scoreboard entry.
  task automatic tick();
    logic [1:0] want;
    @(posedge clk);
    #1;
    if (busy === 1'b1) begin
      if (!prev_busy) busy_runs++;
      busy_cycles++;
      want = (sb_q.size() != 0) ? sb_q.pop_front() : 2'bxx;
      check("sb_jk", {30'b0, j, k}, {30'b0, want});
    end
    prev_busy = (busy === 1'b1);
  endtask

  task automatic push(input logic [1:0] op, input logic [RW-1:0] cnt);
    int n;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_cnt   = cnt;
    if (cmd_if.cmd_ready === 1'b1) begin
      n = (cnt == 0) ? 1 : int'(cnt);
      repeat (n) sb_q.push_back(op);
    end
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy === 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst_n            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_cnt   = '0;
    err_clr          = 1'b0;
    fb_mode          = 2;
    fb_val           = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_j",     {31'b0, j},                32'd0);
    check("rst_k",     {31'b0, k},                32'd0);
    check("rst_busy",  {31'b0, busy},             32'd0);
    check("rst_ready", {31'b0, cmd_if.cmd_ready}, 32'd1);
    check("rst_level", {29'b0, level},            32'd0);
    check("rst_expq",  {31'b0, exp_q},            32'd0);
    check("rst_err",   {31'b0, err},              32'd0);
    rst_n = 1'b1;
    tick();

    // Toggle before any set/reset: checker unarmed, feedback held at 0.
    push(2'b11, 4'd2);
    tick();
    wait_idle("t0_idle", 10);
    repeat (3) tick();
    check("t0_err", {31'b0, err}, 32'd0);

    // Single set for 3 clocks.
    fb_mode     = 0;
    busy_cycles = 0;
    busy_runs   = 0;
    push(2'b10, 4'd3);
    check("t1_level", {29'b0, level}, 32'd1);
    check("t1_busy0", {31'b0, busy},  32'd0);
    tick();
    check("t1_j", {31'b0, j}, 32'd1);
    wait_idle("t1_idle", 20);
    check("t1_busy_cycles", busy_cycles,    32'd3);
    check("t1_busy_runs",   busy_runs,      32'd1);
    check("t1_jk_after",    {30'b0, j, k},  32'd0);
    check("t1_sb_empty",    sb_q.size(),    32'd0);
    repeat (2) tick();
    check("t1_expq", {31'b0, exp_q}, {31'b0, CHK});

    // Back-to-back commands with the stage in the loop: 10,11,11,01 then idle.
    busy_cycles = 0;
    busy_runs   = 0;
    push(2'b10, 4'd1);
    push(2'b11, 4'd2);
    push(2'b01, 4'd0);
    wait_idle("t2_idle", 20);
    check("t2_busy_cycles", busy_cycles,   32'd4);
    check("t2_busy_runs",   busy_runs,     32'd1);
    check("t2_jk_after",    {30'b0, j, k}, 32'd0);
    repeat (3) tick();
    check("t2_expq", {31'b0, exp_q}, 32'd0);
    check("t2_err",  {31'b0, err},   32'd0);

    // Fill the FIFO behind a long command, try a push while full, watch ready recover.
    busy_runs = 0;
    push(2'b10, 4'd15);
    push(2'b01, 4'd2);
    push(2'b10, 4'd1);
    push(2'b11, 4'd1);
    push(2'b00, 4'd2);
    check("t3_level_full", {29'b0, level},            32'd4);
    check("t3_ready_full", {31'b0, cmd_if.cmd_ready}, 32'd0);
    push(2'b11, 4'd5);
    check("t3_level_drop", {29'b0, level}, 32'd4);
    begin
      int n = 0;
      while (cmd_if.cmd_ready !== 1'b1 && n < 30) begin
        tick();
        n++;
      end
    end
    check("t3_ready_back", {31'b0, cmd_if.cmd_ready}, 32'd1);
    check("t3_level_back", {29'b0, level},            32'd3);
    wait_idle("t3_idle", 40);
    check("t3_busy_runs", busy_runs,   32'd1);
    check("t3_sb_empty",  sb_q.size(), 32'd0);
    repeat (3) tick();
    check("t3_err", {31'b0, err}, 32'd0);

    // Mismatch detection, clear-versus-set priority, then clear alone.
    push(2'b10, 4'd4);
    repeat (3) tick();
    fb_mode = 1;
    tick();
    check("t4_err_set", {31'b0, err}, {31'b0, CHK});
    err_clr = 1'b1;
    tick();
    check("t4_err_set_wins", {31'b0, err}, {31'b0, CHK});
    fb_mode = 0;
    tick();
    err_clr = 1'b0;
    check("t4_err_cleared", {31'b0, err}, 32'd0);
    wait_idle("t4_idle", 10);
    check("t4_sb_empty", sb_q.size(), 32'd0);

    // Reset mid-command with two entries queued.
    push(2'b00, 4'd10);
    push(2'b01, 4'd3);
    push(2'b10, 4'd3);
    check("t5_level_pre", {29'b0, level}, 32'd2);
    check("t5_busy_pre",  {31'b0, busy},  32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_jk",    {30'b0, j, k},            32'd0);
    check("t5_rst_busy",  {31'b0, busy},            32'd0);
    check("t5_rst_level", {29'b0, level},           32'd0);
    check("t5_rst_ready", {31'b0, cmd_if.cmd_ready}, 32'd1);
    sb_q.delete();
    prev_busy = 1'b0;
    fb_mode   = 2;
    fb_val    = 1'b1;
    tick();
    rst_n     = 1'b1;
    busy_runs = 0;
    repeat (10) tick();
    check("t5_no_issue", busy_runs,       32'd0);
    check("t5_level",    {29'b0, level},  32'd0);
    check("t5_disarmed", {31'b0, err},    32'd0);
    check("t5_expq",     {31'b0, exp_q},  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
